ppe_input_scheduler: RTL and testbench

//  Sequences the partial-PE array for one convolution: loads filter weights into each PPE, then delivers ifmap rows.

---
 rtl/ppe_input_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_ppe_input_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppe_input_scheduler.sv
// Input scheduler for a partial-PE convolution array: streams filter weights to each PPE,
// then hands out ifmap rows, later rows only on round-robin-arbitrated PPE requests.
module ppe_input_scheduler #(
    parameter int FILTER_SIZE = 5,
    parameter int NUM_PPE     = 5,
    parameter int IFMAP_SIZE  = 25,
    parameter int PPE_BASE_ID = 0,
    localparam int WPKT = (FILTER_SIZE + 1) / 2,
    localparam int WAW  = $clog2(NUM_PPE * WPKT),
    localparam int IAW  = $clog2(IFMAP_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  w_rd_en,
    output logic [WAW-1:0]        w_rd_addr,
    input  logic [15:0]           w_rd_data,
    output logic                  i_rd_en,
    output logic [IAW-1:0]        i_rd_addr,
    input  logic [IFMAP_SIZE-1:0] i_rd_data,
    input  logic [NUM_PPE-1:0]    req_valid,
    output logic [NUM_PPE-1:0]    req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [29:0]           out_packet,
    output logic                  err,
    output logic [2:0]            state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // The sender holds valid and its payload until then; req_ready is a registered one-hot grant.
    localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int PW = (NUM_PPE > 1) ? $clog2(NUM_PPE) : 1;
    localparam int KW = (WPKT > 1) ? $clog2(WPKT) : 1;
    localparam int CW = $clog2(OUTPUT_DIM + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_W_RD, S_W_SEND, S_I_RD, S_I_SEND, S_WAIT_REQ, S_FIN
    } state_t;

    state_t        state;
    logic [PW-1:0] p_idx, gnt_idx, rr, pick_idx, cand;
    logic [KW-1:0] k_idx;
    logic          init_phase, pick_found, all_done, pkt_fresh, pkt_op;
    logic [3:0]    pkt_dest;
    logic [24:0]   pkt_held, pkt_live;
    logic [CW-1:0] sent_cnt [NUM_PPE];
    logic [CW-1:0] req_cnt  [NUM_PPE];

    assign state_dbg = state;

    // Memory data is only valid the cycle after the read, so the first send cycle uses it
    // directly and later (back-pressured) cycles use the copy captured at that edge.
    assign pkt_live   = pkt_op ? 25'(i_rd_data) : 25'(w_rd_data);
    assign out_packet = {pkt_dest, pkt_op, pkt_fresh ? pkt_live : pkt_held};

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_PPE; i++) begin
            cand = PW'((int'(rr) + i) % NUM_PPE);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < NUM_PPE; i++) begin
            if (req_cnt[i] != CW'(OUTPUT_DIM)) all_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            w_rd_en    <= 1'b0;
            w_rd_addr  <= '0;
            i_rd_en    <= 1'b0;
            i_rd_addr  <= '0;
            req_ready  <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            pkt_dest   <= '0;
            pkt_op     <= 1'b0;
            pkt_fresh  <= 1'b0;
            pkt_held   <= '0;
            p_idx      <= '0;
            k_idx      <= '0;
            gnt_idx    <= '0;
            rr         <= '0;
            init_phase <= 1'b0;
            for (int i = 0; i < NUM_PPE; i++) begin
                sent_cnt[i] <= '0;
                req_cnt[i]  <= '0;
            end
        end else begin
            done      <= 1'b0;
            w_rd_en   <= 1'b0;
            i_rd_en   <= 1'b0;
            req_ready <= '0;
            if (pkt_fresh) begin
                pkt_held  <= pkt_live;
                pkt_fresh <= 1'b0;
            end
            case (state)
                S_IDLE: if (start) begin
                    busy       <= 1'b1;
                    init_phase <= 1'b1;
                    p_idx      <= '0;
                    k_idx      <= '0;
                    w_rd_en    <= 1'b1;
                    w_rd_addr  <= '0;
                    for (int i = 0; i < NUM_PPE; i++) begin
                        sent_cnt[i] <= '0;
                        req_cnt[i]  <= '0;
                    end
                    state <= S_W_RD;
                end
                S_W_RD: begin
                    out_valid <= 1'b1;
                    pkt_dest  <= 4'(PPE_BASE_ID + int'(p_idx));
                    pkt_op    <= 1'b0;
                    pkt_fresh <= 1'b1;
                    state     <= S_W_SEND;
                end
                S_W_SEND: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (k_idx == KW'(WPKT - 1) && p_idx == PW'(NUM_PPE - 1)) begin
                        k_idx     <= '0;
                        p_idx     <= '0;
                        i_rd_en   <= 1'b1;
                        i_rd_addr <= '0;
                        state     <= S_I_RD;
                    end else begin
                        if (k_idx == KW'(WPKT - 1)) begin
                            k_idx <= '0;
                            p_idx <= p_idx + 1'b1;
                        end else begin
                            k_idx <= k_idx + 1'b1;
                        end
                        w_rd_en   <= 1'b1;
                        w_rd_addr <= w_rd_addr + 1'b1;
                        state     <= S_W_RD;
                    end
                end
                S_I_RD: begin
                    out_valid <= 1'b1;
                    pkt_dest  <= 4'(PPE_BASE_ID + int'(p_idx));
                    pkt_op    <= 1'b1;
                    pkt_fresh <= 1'b1;
                    state     <= S_I_SEND;
                end
                S_I_SEND: if (out_ready) begin
                    out_valid       <= 1'b0;
                    sent_cnt[p_idx] <= sent_cnt[p_idx] + 1'b1;
                    if (init_phase && p_idx != PW'(NUM_PPE - 1)) begin
                        p_idx     <= p_idx + 1'b1;
                        i_rd_en   <= 1'b1;
                        i_rd_addr <= i_rd_addr + 1'b1;
                        state     <= S_I_RD;
                    end else begin
                        init_phase <= 1'b0;
                        state      <= S_WAIT_REQ;
                    end
                end
                S_WAIT_REQ: begin
                    if (req_ready != '0) begin
                        // Grant cycle: the PPE holds its request, so the transfer completes here.
                        if ((req_valid & req_ready) != '0) begin
                            rr <= (gnt_idx == PW'(NUM_PPE - 1)) ? '0 : gnt_idx + 1'b1;
                            if (req_cnt[gnt_idx] == CW'(OUTPUT_DIM)) begin
                                err <= 1'b1;
                            end else begin
                                req_cnt[gnt_idx] <= req_cnt[gnt_idx] + 1'b1;
                                if (sent_cnt[gnt_idx] < CW'(OUTPUT_DIM)) begin
                                    p_idx     <= gnt_idx;
                                    i_rd_en   <= 1'b1;
                                    i_rd_addr <= IAW'(int'(gnt_idx) + int'(sent_cnt[gnt_idx]));
                                    state     <= S_I_RD;
                                end
                            end
                        end
                    end else if (all_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end else if (pick_found) begin
                        req_ready <= NUM_PPE'(1) << pick_idx;
                        gnt_idx   <= pick_idx;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ppe_input_scheduler.sv
// Self-checking bench for ppe_input_scheduler: memory models, a packet/grant reference model
// with an expected-packet queue, a directed arbitration table and a randomized full layer.
module tb_ppe_input_scheduler;
    localparam int NP   = 5;
    localparam int WP   = 3;
    localparam int OD   = 21;
    localparam int ISZ  = 25;
    localparam int BASE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [NP-1:0] req_valid = '0;
    logic        busy, done, w_rd_en, i_rd_en, out_valid, err;
    logic [3:0]  w_rd_addr;
    logic [15:0] w_rd_data;
    logic [4:0]  i_rd_addr;
    logic [24:0] i_rd_data;
    logic [NP-1:0] req_ready;
    logic [29:0] out_packet;
    logic [2:0]  state_dbg;

    ppe_input_scheduler #(.FILTER_SIZE(5), .NUM_PPE(NP), .IFMAP_SIZE(ISZ), .PPE_BASE_ID(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
        .req_valid(req_valid), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- memories ----------------
    logic [15:0] wmem [16];
    logic [24:0] imem [ISZ];

    always @(posedge clk) begin
        w_rd_data <= w_rd_en ? wmem[w_rd_addr] : 16'($urandom);
        i_rd_data <= i_rd_en ? imem[i_rd_addr] : 25'($urandom);
    end

    // ---------------- scoreboard / reference model ----------------
    logic [29:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int m_rr, m_req[NP], m_sent[NP];
    logic m_err;
    int n_pkts, n_w, n_i, n_done, n_grants, n_i_per[NP], quota[NP];
    logic [29:0] pkt_log[8];
    logic [NP-1:0] hs_seen, rv_prev;
    logic stall_prev = 1'b0;
    logic [29:0] pkt_prev;
    int mq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] v, input int rr);
        for (int i = 0; i < NP; i++) begin
            if (v[(rr + i) % NP]) return NP'(1) << ((rr + i) % NP);
        end
        return '0;
    endfunction

    function automatic int oh_idx(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("pkt_hold", 64'({out_valid, out_packet}), 64'({1'b1, pkt_prev}));
            check("err", 64'(err), 64'(m_err));
            if (done) begin
                n_done++;
                check("busy_at_done", 64'(busy), 64'(0));
                check("model_done", 64'(m_req[0] == OD && m_req[1] == OD && m_req[2] == OD &&
                                        m_req[3] == OD && m_req[4] == OD), 64'(1));
            end
            if (req_ready != '0) begin
                check("grant", 64'(req_ready), 64'(rr_pick(rv_prev, m_rr)));
                if ((req_valid & req_ready) != '0) begin
                    mq = oh_idx(req_ready);
                    hs_seen[mq] = 1'b1;
                    n_grants++;
                    m_rr = (mq + 1) % NP;
                    if (m_req[mq] == OD) begin
                        m_err = 1'b1;
                    end else begin
                        m_req[mq]++;
                        if (m_sent[mq] < OD) begin
                            exp_q.push_back({4'(BASE + mq), 1'b1, imem[mq + m_sent[mq]]});
                            m_sent[mq]++;
                        end
                    end
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_pkt: got %h expected none", out_packet);
                end else begin
                    check("pkt", 64'(out_packet), 64'(exp_q.pop_front()));
                end
                if (n_pkts < 8) pkt_log[n_pkts] = out_packet;
                n_pkts++;
                if (out_packet[25]) begin
                    n_i++;
                    if (int'(out_packet[29:26]) - BASE inside {[0:NP-1]})
                        n_i_per[int'(out_packet[29:26]) - BASE]++;
                end else begin
                    n_w++;
                end
            end
            stall_prev = out_valid && !out_ready;
            pkt_prev   = out_packet;
        end
        rv_prev = req_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_model();
        m_rr = 0;
        m_err = 1'b0;
        exp_q.delete();
        hs_seen = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic start_layer();
        exp_q.delete();
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < WP; k++)
                exp_q.push_back({4'(BASE + p), 1'b0, 9'b0, wmem[p * WP + k]});
        for (int p = 0; p < NP; p++) begin
            exp_q.push_back({4'(BASE + p), 1'b1, imem[p]});
            m_sent[p] = 1;
            m_req[p] = 0;
            n_i_per[p] = 0;
        end
        n_pkts = 0; n_w = 0; n_i = 0; n_done = 0; n_grants = 0;
        hs_seen = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_init_rows(input string name);
        for (int c = 0; c < 300 && n_i < NP; c++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(n_i), 64'(NP));
    endtask

    // Each PPE raises a request with probability pct while it has quota, holds it until granted.
    task automatic run_requests(input int pct, input bit rnd, input int budget);
        int left;
        left = 1;
        for (int c = 0; c < budget && left != 0; c++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs_seen[p]) begin
                    req_valid[p] = 1'b0;
                    if (quota[p] > 0) quota[p]--;
                end
            end
            hs_seen = '0;
            for (int p = 0; p < NP; p++)
                if (!req_valid[p] && quota[p] > 0 && $urandom_range(0, 99) < pct) req_valid[p] = 1'b1;
            if (rnd) begin
                out_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 19) == 0);
            end
            left = 0;
            for (int p = 0; p < NP; p++) left += quota[p];
            if (req_valid != '0) left++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("req_drain", 64'(left), 64'(0));
    endtask

    task automatic wait_done();
        for (int c = 0; c < 300 && n_done == 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 64'(n_done), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    typedef struct {
        logic [NP-1:0] raise;
        int            exp_gnt;
    } arb_vec_t;

    arb_vec_t arb_tbl [13];

    initial begin
        logic [29:0] p2;
        logic [NP-1:0] got;
        int extra;

        for (int i = 0; i < 16; i++) wmem[i] = 16'($urandom);
        for (int i = 0; i < ISZ; i++) imem[i] = 25'($urandom);
        arb_tbl[0]  = '{5'b10101, 0};
        arb_tbl[1]  = '{5'b00000, 2};
        arb_tbl[2]  = '{5'b00000, 4};
        arb_tbl[3]  = '{5'b10101, 0};
        arb_tbl[4]  = '{5'b00010, 1};
        arb_tbl[5]  = '{5'b00000, 2};
        arb_tbl[6]  = '{5'b01000, 3};
        arb_tbl[7]  = '{5'b00000, 4};
        arb_tbl[8]  = '{5'b11111, 0};
        arb_tbl[9]  = '{5'b00000, 1};
        arb_tbl[10] = '{5'b00000, 2};
        arb_tbl[11] = '{5'b00000, 3};
        arb_tbl[12] = '{5'b00000, 4};

        // T1: reset values, reset in the middle of a stalled weight packet
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_outputs", 64'({done, w_rd_en, i_rd_en, req_ready, err, out_packet}), 64'(0));
        start_layer();
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        check("t1_w_send", 64'(out_valid), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t1_rst_valid", 64'(out_valid), 64'(0));
        check("t1_rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        clear_model();
        start_layer();
        check("t1_restart", 64'({w_rd_en, busy, w_rd_addr}), 64'({1'b1, 1'b1, 4'd0}));

        // T2/T3: weight packets with back-pressure on the second one
        do_reset();
        out_ready = 1'b1;
        start_layer();
        for (int c = 0; c < 20 && n_pkts < 1; c++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        p2 = out_packet;
        check("bp_first", 64'({out_valid, p2}), 64'({1'b1, 4'(BASE), 1'b0, 9'b0, wmem[1]}));
        extra = 0;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (w_rd_en) extra++;
        end
        check("bp_no_rd", 64'(extra), 64'(0));
        check("bp_pkt", 64'({out_valid, out_packet}), 64'({1'b1, p2}));
        out_ready = 1'b1;
        wait_init_rows("t2_init_rows");
        check("t2_w_count", 64'(n_w), 64'(15));
        check("t2_pkt4", 64'(pkt_log[3]), 64'({4'(BASE + 1), 1'b0, 9'b0, wmem[3]}));

        // T4: round-robin arbitration table
        do_reset();
        out_ready = 1'b1;
        start_layer();
        wait_init_rows("t4_init_rows");
        for (int t = 0; t < 13; t++) begin
            req_valid = req_valid | arb_tbl[t].raise;
            got = '0;
            for (int c = 0; c < 60 && got == '0; c++) begin
                @(negedge clk);
                got = req_ready;
            end
            check("arb_tbl", 64'(got), 64'(NP'(1) << arb_tbl[t].exp_gnt));
            @(posedge clk);
            #1;
            req_valid = req_valid & ~got;
        end

        // T6: excess request from PPE1, then the rest of the layer
        do_reset();
        out_ready = 1'b1;
        start_layer();
        wait_init_rows("t6_init_rows");
        quota = '{0, 22, 0, 0, 0};
        run_requests(100, 1'b0, 600);
        repeat (8) @(posedge clk);
        #1;
        check("t6_err", 64'(err), 64'(1));
        check("t6_no_pkt", 64'(n_i), 64'(25));
        quota = '{21, 0, 21, 21, 21};
        run_requests(100, 1'b0, 3000);
        wait_done();
        check("t6_inputs", 64'(n_i), 64'(105));
        check("t6_err_sticky", 64'(err), 64'(1));

        // T5: randomized full layer with back-pressure and stray start pulses
        do_reset();
        out_ready = 1'b1;
        quota = '{21, 21, 21, 21, 21};
        start_layer();
        run_requests(30, 1'b1, 8000);
        wait_done();
        check("t5_w_count", 64'(n_w), 64'(15));
        check("t5_inputs", 64'(n_i), 64'(105));
        check("t5_grants", 64'(n_grants), 64'(105));
        check("t5_queue_empty", 64'(exp_q.size()), 64'(0));
        for (int p = 0; p < NP; p++) check("t5_rows_per_ppe", 64'(n_i_per[p]), 64'(OD));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
